// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int unsigned N_DEFAULT = 4;
  localparam int unsigned CNT_W     = $clog2(N_DEFAULT) + 1;

  // Iteration counter width for an operand width n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/seq_restoring_div_if.sv
// Request/result bundle of the sequential restoring divider.
interface seq_restoring_div_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   r,
  input  logic         q_msb,
  input  logic [N-1:0] d,
  output logic [N:0]   r_next,
  output logic         q_bit
);
  logic [N+1:0] shifted;
  logic [N:0]   diff;

  // r[N] is always 0 between steps, so including it in the compare matches
  // the sign test on {r[N-1:0], q_msb} - {1'b0, d}.
  always_comb begin
    shifted = {r, q_msb};
    q_bit   = (shifted >= {2'b00, d});
    diff    = shifted[N:0] - {1'b0, d};
    r_next  = q_bit ? diff : shifted[N:0];
  end
endmodule

// File: rtl/seq_restoring_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIV_EARLY_TERM_EN: a zero dividend skips CALC.
module seq_restoring_div
  import seq_div_pkg::*;
#(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst,
  seq_restoring_div_if.slave bus
);
  localparam int unsigned CW = cnt_w(N);

  div_state_t   state;
  logic [N:0]   r;
  logic [N-1:0] q;
  logic [N-1:0] d;
  logic [CW-1:0] cnt;
  logic [N-1:0] quot_r;
  logic [N-1:0] rem_r;
  logic         busy_r;
  logic         done_r;
  logic         dbz_r;
  logic [N:0]   r_next;
  logic         q_bit;

  div_step #(.N(N)) u_step (
    .r      (r),
    .q_msb  (q[N-1]),
    .d      (d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // FSM, iteration counter, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      r      <= '0;
      q      <= '0;
      d      <= '0;
      cnt    <= '0;
      quot_r <= '0;
      rem_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            r   <= '0;
            q   <= bus.dividend;
            d   <= bus.divisor;
            cnt <= '0;
`ifdef SEQ_DIV_EARLY_TERM_EN
            if (bus.dividend == '0) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              dbz_r  <= (bus.divisor == '0);
              quot_r <= (bus.divisor == '0) ? '1 : '0;
              rem_r  <= '0;
            end else
`endif
            begin
              state  <= CALC;
              busy_r <= 1'b1;
            end
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        CALC: begin
          r   <= r_next;
          q   <= {q[N-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            dbz_r  <= (d == '0);
            quot_r <= {q[N-2:0], q_bit};
            rem_r  <= r_next[N-1:0];
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
endmodule
